// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors referee: punch codes,
// result codes, FSM states and the punch compare helpers.
package rps_pkg;

    localparam logic [3:0] PUNCH_NONE     = 4'b0000;
    localparam logic [3:0] PUNCH_SCISSORS = 4'b0001;
    localparam logic [3:0] PUNCH_STONE    = 4'b0010;
    localparam logic [3:0] PUNCH_PAPER    = 4'b0100;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } res_e;

    typedef enum logic [2:0] {
        ARM     = 3'd0,
        COLLECT = 3'd1,
        JUDGE   = 3'd2,
        SHOW    = 3'd3,
        OVER    = 3'd4
    } state_e;

    // Multi-hot codes and anything with bit 3 set count as no punch.
    function automatic logic punch_valid(input logic [3:0] p);
        return (p == PUNCH_SCISSORS) || (p == PUNCH_STONE) ||
               (p == PUNCH_PAPER);
    endfunction

    function automatic logic beats(input logic [3:0] a,
                                   input logic [3:0] b);
        return ((a == PUNCH_STONE)    && (b == PUNCH_SCISSORS)) ||
               ((a == PUNCH_SCISSORS) && (b == PUNCH_PAPER))    ||
               ((a == PUNCH_PAPER)    && (b == PUNCH_STONE));
    endfunction

endpackage

// File: rtl/rps_referee_if.sv
// Punch inputs, tick/restart controls and score/result indicators
// between the display stage and the referee.
interface rps_referee_if;

    logic [3:0] punch_1;
    logic [3:0] punch_2;
    logic       tick;
    logic       new_match;
    logic [1:0] result;
    logic       result_valid;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       match_over;
    logic [1:0] winner;

    modport master (
        output punch_1, punch_2, tick, new_match,
        input  result, result_valid, score_1, score_2,
        input  match_over, winner
    );

    modport slave (
        input  punch_1, punch_2, tick, new_match,
        output result, result_valid, score_1, score_2,
        output match_over, winner
    );

endinterface

// File: rtl/rps_judge.sv
// Combinational round judge: compares two latched one-hot punches and
// returns the result code.
module rps_judge
    import rps_pkg::*;
(
    input  logic [3:0] p1,
    input  logic [3:0] p2,
    output res_e       res
);

    always_comb begin
        res = RES_NONE;
        unique case (1'b1)
            (p1 == p2):   res = RES_DRAW;
            beats(p1, p2): res = RES_P1;
            beats(p2, p1): res = RES_P2;
            default:      res = RES_NONE;
        endcase
    end

endmodule

// File: rtl/rps_referee.sv
// Rock-paper-scissors referee: latches punches, judges, shows, scores.
// Define RPS_TIMEOUT_EN to add the single-player forfeit timeout.
module rps_referee
    import rps_pkg::*;
#(
    parameter int WIN_SCORE     = 3,
    parameter int SHOW_TICKS    = 4,
    parameter int TIMEOUT_TICKS = 16
)
(
    input  logic          CLK,
    input  logic          Clear,
    rps_referee_if.slave  io
);

    // One tick counter serves both the show hold and the forfeit window.
    localparam int CNT_MAX = (SHOW_TICKS > TIMEOUT_TICKS) ?
                             SHOW_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHOW_LIM = CNT_W'(SHOW_TICKS);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

    state_e            state_q, state_d;
    logic [3:0]        p1_q, p1_d;
    logic [3:0]        p2_q, p2_d;
    logic [3:0]        s1_q, s1_d;
    logic [3:0]        s2_q, s2_d;
    res_e              res_q, res_d;
    logic              rv_q, rv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    res_e              judge_res;
    res_e              award;
    logic              lat1, lat2;
    logic              take1, take2;
    logic              both_now;
    logic              inputs_idle;
    logic              show_done;
    logic              win_reached;
    logic              to_fire;
    logic [CNT_W-1:0]  cnt_inc;

    rps_judge u_judge (
        .p1  (p1_q),
        .p2  (p2_q),
        .res (judge_res)
    );

    assign lat1        = (p1_q != PUNCH_NONE);
    assign lat2        = (p2_q != PUNCH_NONE);
    assign take1       = !lat1 && punch_valid(io.punch_1);
    assign take2       = !lat2 && punch_valid(io.punch_2);
    assign both_now    = (lat1 || take1) && (lat2 || take2);
    assign inputs_idle = (io.punch_1 == PUNCH_NONE) &&
                         (io.punch_2 == PUNCH_NONE);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign show_done   = (state_q == SHOW) && io.tick &&
                         (cnt_inc == SHOW_LIM);
    assign win_reached = (s1_q == WIN) || (s2_q == WIN);

`ifdef RPS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_TICKS);

    logic one_waiting;

    assign one_waiting = (state_q == COLLECT) && (lat1 ^ lat2) &&
                         !both_now;
    assign to_fire     = one_waiting && io.tick && (cnt_inc == TO_LIM);
`else
    assign to_fire     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state_q <= ARM;
            p1_q    <= PUNCH_NONE;
            p2_q    <= PUNCH_NONE;
            s1_q    <= '0;
            s2_q    <= '0;
            res_q   <= RES_NONE;
            rv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (io.new_match) begin
            state_d = ARM;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (inputs_idle) state_d = COLLECT;
                end
                COLLECT: begin
                    if (to_fire)       state_d = SHOW;
                    else if (both_now) state_d = JUDGE;
                end
                JUDGE: state_d = SHOW;
                SHOW: begin
                    if (show_done) state_d = win_reached ? OVER : ARM;
                end
                OVER:    state_d = OVER;
                default: state_d = ARM;
            endcase
        end
    end

    always_comb begin
        p1_d  = p1_q;
        p2_d  = p2_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        res_d = res_q;
        rv_d  = 1'b0;
        cnt_d = cnt_q;
        award = RES_NONE;
        if (io.new_match) begin
            p1_d  = PUNCH_NONE;
            p2_d  = PUNCH_NONE;
            s1_d  = '0;
            s2_d  = '0;
            res_d = RES_NONE;
            cnt_d = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (take1) p1_d = io.punch_1;
                    if (take2) p2_d = io.punch_2;
                    cnt_d = '0;
`ifdef RPS_TIMEOUT_EN
                    if (one_waiting && io.tick) cnt_d = cnt_inc;
`endif
                    if (to_fire) begin
                        award = lat1 ? RES_P1 : RES_P2;
                        cnt_d = '0;
                    end
                end
                JUDGE: begin
                    award = judge_res;
                    cnt_d = '0;
                end
                SHOW: begin
                    if (io.tick) cnt_d = cnt_inc;
                    if (show_done) begin
                        cnt_d = '0;
                        if (!win_reached) begin
                            res_d = RES_NONE;
                            p1_d  = PUNCH_NONE;
                            p2_d  = PUNCH_NONE;
                        end
                    end
                end
                default: cnt_d = '0;
            endcase
            if (award != RES_NONE) begin
                res_d = award;
                rv_d  = 1'b1;
                if (award == RES_P1) s1_d = s1_q + 4'd1;
                if (award == RES_P2) s2_d = s2_q + 4'd1;
            end
        end
    end

    always_comb begin
        io.match_over = (state_q == OVER);
        io.winner     = RES_NONE;
        if (state_q == OVER) begin
            if (s1_q == WIN)      io.winner = RES_P1;
            else if (s2_q == WIN) io.winner = RES_P2;
        end
    end

    assign io.result       = res_q;
    assign io.result_valid = rv_q;
    assign io.score_1      = s1_q;
    assign io.score_2      = s2_q;

endmodule

// File: tb/tb_rps_referee.sv
// Directed bench for rps_referee: table of full rounds plus hand-written
// sequences for held punches, restart, async clear and the forfeit timeout.
module tb_rps_referee;
    import rps_pkg::*;

    localparam int SHOW_T = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] r;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       over;
        logic [1:0] w;
    } vec_t;

    logic CLK = 1'b0;
    logic Clear;
    int   n_cmp = 0;
    int   n_err = 0;

    rps_referee_if io ();

    rps_referee #(
        .WIN_SCORE     (3),
        .SHOW_TICKS    (SHOW_T),
        .TIMEOUT_TICKS (16)
    ) dut (
        .CLK   (CLK),
        .Clear (Clear),
        .io    (io)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            io.tick = 1'b1;
            cyc(1);
            io.tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic round(input string tag, input vec_t v);
        io.punch_1 = PUNCH_NONE;
        io.punch_2 = PUNCH_NONE;
        cyc(2);
        io.punch_1 = v.a;
        io.punch_2 = v.b;
        cyc(1);
        chk({tag, "_rv_early"}, io.result_valid, 0);
        cyc(1);
        chk({tag, "_rv"}, io.result_valid, 1);
        chk({tag, "_res"}, io.result, v.r);
        chk({tag, "_s1"}, io.score_1, v.s1);
        chk({tag, "_s2"}, io.score_2, v.s2);
        io.punch_1 = PUNCH_NONE;
        io.punch_2 = PUNCH_NONE;
        cyc(1);
        chk({tag, "_rv_pulse"}, io.result_valid, 0);
        ticks(SHOW_T - 1);
        chk({tag, "_res_hold"}, io.result, v.r);
        ticks(1);
        if (v.over) begin
            chk({tag, "_over"}, io.match_over, 1);
            chk({tag, "_winner"}, io.winner, v.w);
        end else begin
            chk({tag, "_res_clr"}, io.result, 0);
            chk({tag, "_not_over"}, io.match_over, 0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_res"}, io.result, 0);
        chk({tag, "_rv"}, io.result_valid, 0);
        chk({tag, "_s1"}, io.score_1, 0);
        chk({tag, "_s2"}, io.score_2, 0);
        chk({tag, "_over"}, io.match_over, 0);
        chk({tag, "_winner"}, io.winner, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vec_t v;
        logic any_rv;
        int   seen;
        logic [1:0] seen_res;

        vt[0] = '{PUNCH_STONE,    PUNCH_SCISSORS, 2'b01, 4'd1, 4'd0, 1'b0, 2'b00};
        vt[1] = '{PUNCH_PAPER,    PUNCH_PAPER,    2'b11, 4'd1, 4'd0, 1'b0, 2'b00};
        vt[2] = '{PUNCH_SCISSORS, PUNCH_PAPER,    2'b01, 4'd2, 4'd0, 1'b0, 2'b00};
        vt[3] = '{PUNCH_STONE,    PUNCH_PAPER,    2'b10, 4'd2, 4'd1, 1'b0, 2'b00};
        vt[4] = '{PUNCH_SCISSORS, PUNCH_STONE,    2'b10, 4'd2, 4'd2, 1'b0, 2'b00};
        vt[5] = '{PUNCH_STONE,    PUNCH_STONE,    2'b11, 4'd2, 4'd2, 1'b0, 2'b00};
        vt[6] = '{PUNCH_SCISSORS, PUNCH_SCISSORS, 2'b11, 4'd2, 4'd2, 1'b0, 2'b00};
        vt[7] = '{PUNCH_PAPER,    PUNCH_SCISSORS, 2'b10, 4'd2, 4'd3, 1'b1, 2'b10};

        Clear        = 1'b1;
        io.punch_1   = PUNCH_NONE;
        io.punch_2   = PUNCH_NONE;
        io.tick      = 1'b0;
        io.new_match = 1'b0;
        cyc(2);
        chk_reset("reset");
        Clear = 1'b0;

        for (int i = 0; i < 8; i++)
            round($sformatf("v%0d", i), vt[i]);

        // Match is over: punches must not start a round.
        io.punch_1 = PUNCH_STONE;
        io.punch_2 = PUNCH_SCISSORS;
        any_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            any_rv |= io.result_valid;
        end
        chk("over_ignore_rv", any_rv, 0);
        chk("over_ignore_s1", io.score_1, 2);
        chk("over_ignore_s2", io.score_2, 3);
        chk("over_hold", io.match_over, 1);

        io.punch_1   = PUNCH_NONE;
        io.punch_2   = PUNCH_NONE;
        io.new_match = 1'b1;
        #1;
        chk("nm_sync_wait", io.match_over, 1);
        cyc(1);
        io.new_match = 1'b0;
        chk_reset("new_match");

        // First punch kept despite later change; invalid codes ignored.
        cyc(2);
        io.punch_1 = PUNCH_PAPER;
        io.punch_2 = 4'b0011;
        cyc(2);
        io.punch_1 = PUNCH_SCISSORS;
        io.punch_2 = 4'b1000;
        cyc(2);
        io.punch_2 = 4'b0110;
        cyc(1);
        io.punch_2 = PUNCH_PAPER;
        cyc(1);
        chk("late_rv_early", io.result_valid, 0);
        cyc(1);
        chk("late_rv", io.result_valid, 1);
        chk("late_res", io.result, 2'b11);
        chk("late_s1", io.score_1, 0);
        chk("late_s2", io.score_2, 0);

        // Held punch_2 through SHOW must block the next round.
        io.punch_1 = PUNCH_NONE;
        io.punch_2 = PUNCH_STONE;
        ticks(SHOW_T);
        chk("held_res_clr", io.result, 0);
        io.punch_1 = 4'b0011;
        any_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            any_rv |= io.result_valid;
        end
        io.punch_1 = PUNCH_SCISSORS;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            any_rv |= io.result_valid;
        end
        chk("held_no_round", any_rv, 0);
        chk("held_res", io.result, 0);
        v = '{PUNCH_PAPER, PUNCH_STONE, 2'b01, 4'd1, 4'd0, 1'b0, 2'b00};
        round("after_held", v);

        // Asynchronous Clear in the middle of SHOW.
        io.punch_1 = PUNCH_NONE;
        io.punch_2 = PUNCH_NONE;
        cyc(2);
        io.punch_1 = PUNCH_STONE;
        io.punch_2 = PUNCH_SCISSORS;
        cyc(2);
        chk("pre_clr_s1", io.score_1, 2);
        ticks(1);
        #2;
        Clear = 1'b1;
        #1;
        chk_reset("clear_async");
        cyc(1);
        Clear = 1'b0;
        v = '{PUNCH_STONE, PUNCH_SCISSORS, 2'b01, 4'd1, 4'd0, 1'b0, 2'b00};
        round("after_clr", v);

        // Only player 1 punches.
        io.punch_1 = PUNCH_NONE;
        io.punch_2 = PUNCH_NONE;
        cyc(2);
        io.punch_1 = PUNCH_SCISSORS;
        cyc(1);
        seen = 0;
        seen_res = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            io.tick = 1'b1;
            cyc(1);
            if (io.result_valid && seen == 0) begin
                seen = i;
                seen_res = io.result;
            end
            io.tick = 1'b0;
            cyc(1);
            if (io.result_valid && seen == 0) begin
                seen = i;
                seen_res = io.result;
            end
        end
`ifdef RPS_TIMEOUT_EN
        chk("to_tick", 8'(seen), 16);
        chk("to_res", seen_res, 2'b01);
        chk("to_s1", io.score_1, 2);
        chk("to_s2", io.score_2, 0);
`else
        chk("no_to_tick", 8'(seen), 0);
        chk("no_to_res", io.result, 0);
        chk("no_to_s1", io.score_1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
